// File: rtl/fpu_seq_normalizer_if.sv
// Handshake bundle for the sequential FPU normalizer.
// The master drives operands and accepts results. The slave is the normalizer.
interface fpu_seq_normalizer_if #(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [MANTISSA_SIZE+1:0] in_mantissa;
  logic [EXPONENT_SIZE-1:0] in_exponent;
  logic                     out_valid;
  logic                     out_ready;
  logic [MANTISSA_SIZE-1:0] out_mantissa;
  logic [EXPONENT_SIZE-1:0] out_exponent;
  logic                     overflow;
  logic                     underflow;
  logic                     zero;

  modport master (
    output in_valid, in_mantissa, in_exponent, out_ready,
    input  in_ready, out_valid, out_mantissa, out_exponent, overflow, underflow, zero
  );

  modport slave (
    input  in_valid, in_mantissa, in_exponent, out_ready,
    output in_ready, out_valid, out_mantissa, out_exponent, overflow, underflow, zero
  );
endinterface

// File: rtl/fpu_seq_normalizer.sv
// Multi-cycle FPU mantissa normalizer.
// The easy cases are classified in one cycle: Inf/NaN, zero, carry, already normalised, and denormal.
// All other operands are shifted left by at most SHIFT_PER_CYCLE bits per clock.
module fpu_seq_normalizer #(
  parameter int MANTISSA_SIZE   = 23,
  parameter int EXPONENT_SIZE   = 8,
  parameter int SHIFT_PER_CYCLE = 4
) (
  input logic clk,
  input logic rst,
  fpu_seq_normalizer_if.slave bus
);

  localparam int MW  = MANTISSA_SIZE + 2;
  localparam int EW  = EXPONENT_SIZE + 1;
  localparam int LZW = $clog2(MANTISSA_SIZE + 2);
  localparam int CW  = (EW > LZW) ? EW : LZW;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_next;
  logic [MW-1:0]   mant_reg, mant_next;
  logic [EW-1:0]   exp_reg, exp_next;
  logic            overflow_reg, overflow_next;
  logic            underflow_reg, underflow_next;
  logic            zero_reg, zero_next;

  logic [LZW-1:0]  lz;
  logic [CW-1:0]   shift_amt;
  logic [CW-1:0]   exp_minus_one;
  logic [MW-1:0]   mant_shifted;
  logic [EW-1:0]   exp_shifted;

  // Count the leading zeros above and including the hidden bit. The highest set bit wins.
  always_comb begin
    lz = LZW'(MANTISSA_SIZE + 1);
    for (int i = 0; i <= MANTISSA_SIZE; i++) begin
      if (mant_reg[i]) lz = LZW'(MANTISSA_SIZE - i);
    end
  end

  // Bound the shift by the leading zeros, the per-cycle limit, and the exponent floor of 1.
  always_comb begin
    exp_minus_one = CW'(exp_reg - EW'(1));
    shift_amt     = CW'(lz);
    if (CW'(SHIFT_PER_CYCLE) < shift_amt) shift_amt = CW'(SHIFT_PER_CYCLE);
    if (exp_minus_one < shift_amt)        shift_amt = exp_minus_one;
    mant_shifted  = mant_reg << shift_amt;
    exp_shifted   = exp_reg - EW'(shift_amt);
  end

  // Compute the next state and the next result registers. Classification happens at accept time.
  always_comb begin
    state_next     = state;
    mant_next      = mant_reg;
    exp_next       = exp_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    zero_next      = zero_reg;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          mant_next      = bus.in_mantissa;
          exp_next       = {1'b0, bus.in_exponent};
          overflow_next  = 1'b0;
          underflow_next = 1'b0;
          zero_next      = 1'b0;
          state_next     = DONE;
          if (&bus.in_exponent) begin
            state_next = DONE;
          end else if (bus.in_mantissa == '0) begin
            exp_next  = '0;
            zero_next = 1'b1;
          end else if (bus.in_mantissa[MANTISSA_SIZE+1]) begin
            mant_next = bus.in_mantissa >> 1;
            exp_next  = {1'b0, bus.in_exponent} + EW'(1);
            if (&exp_next[EXPONENT_SIZE-1:0]) begin
              overflow_next = 1'b1;
              mant_next     = '0;
            end
          end else if (bus.in_mantissa[MANTISSA_SIZE]) begin
            state_next = DONE;
          end else if (bus.in_exponent <= EXPONENT_SIZE'(1)) begin
            underflow_next = 1'b1;
            exp_next       = '0;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        mant_next = mant_shifted;
        exp_next  = exp_shifted;
        if (mant_shifted[MANTISSA_SIZE]) begin
          state_next = DONE;
        end else if (exp_shifted == EW'(1)) begin
          underflow_next = 1'b1;
          exp_next       = '0;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          overflow_next  = 1'b0;
          underflow_next = 1'b0;
          zero_next      = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Register the state and results. Reset drops any in-flight operand and clears the flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mant_reg      <= '0;
      exp_reg       <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      zero_reg      <= 1'b0;
    end else begin
      state         <= state_next;
      mant_reg      <= mant_next;
      exp_reg       <= exp_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      zero_reg      <= zero_next;
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = (state == DONE);
  assign bus.out_mantissa = mant_reg[MANTISSA_SIZE-1:0];
  assign bus.out_exponent = exp_reg[EXPONENT_SIZE-1:0];
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;
  assign bus.zero         = zero_reg;

endmodule

// File: tb/tb_fpu_seq_normalizer.sv
// Directed testbench for fpu_seq_normalizer with the default parameters (M=23, E=8, K=4).
module tb_fpu_seq_normalizer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   lat;

  fpu_seq_normalizer_if #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8)) bus ();

  fpu_seq_normalizer #(
    .MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .SHIFT_PER_CYCLE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present an operand for one accept edge and return the number of edges until out_valid.
  task automatic apply_stimulus(input string tag, input logic [24:0] mant, input logic [7:0] expo,
                                output int cycles);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_mantissa = mant;
    bus.in_exponent = expo;
    tick();
    bus.in_valid    = 1'b0;
    cycles = 1;
    while (!bus.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  // Compare the result fields and flags, then complete the output handshake.
  task automatic check_output(input string tag, input int cycles, input int exp_cycles,
                              input logic [22:0] mant, input logic [7:0] expo,
                              input logic ovf, input logic unf, input logic zr);
    check({tag, ".latency"},   32'(cycles),           32'(exp_cycles));
    check({tag, ".out_valid"}, 32'(bus.out_valid),    32'd1);
    check({tag, ".mantissa"},  32'(bus.out_mantissa), 32'(mant));
    check({tag, ".exponent"},  32'(bus.out_exponent), 32'(expo));
    check({tag, ".flags"},     32'({bus.overflow, bus.underflow, bus.zero}), 32'({ovf, unf, zr}));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".post_ready"}, 32'(bus.in_ready),  32'd1);
    check({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".post_flags"}, 32'({bus.overflow, bus.underflow, bus.zero}), 32'd0);
  endtask

  // Linear sequence of directed steps.
  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_mantissa = '0;
    bus.in_exponent = '0;
    bus.out_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    $display("[TB] reset state");
    check("reset.in_ready",  32'(bus.in_ready),     32'd1);
    check("reset.out_valid", 32'(bus.out_valid),    32'd0);
    check("reset.mantissa",  32'(bus.out_mantissa), 32'd0);
    check("reset.exponent",  32'(bus.out_exponent), 32'd0);
    check("reset.flags",     32'({bus.overflow, bus.underflow, bus.zero}), 32'd0);

    $display("[TB] carry case");
    apply_stimulus("carry", 25'h1000000, 8'h80, lat);
    check_output("carry", lat, 1, 23'h000000, 8'h81, 1'b0, 1'b0, 1'b0);

    $display("[TB] shift lz=5");
    apply_stimulus("lz5", 25'h0040000, 8'h80, lat);
    check_output("lz5", lat, 3, 23'h000000, 8'h7B, 1'b0, 1'b0, 1'b0);

    $display("[TB] shift into underflow");
    apply_stimulus("unf_shift", 25'h0000001, 8'h05, lat);
    check_output("unf_shift", lat, 2, 23'h000010, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("[TB] overflow");
    apply_stimulus("ovf", 25'h1800000, 8'hFE, lat);
    check_output("ovf", lat, 1, 23'h000000, 8'hFF, 1'b1, 1'b0, 1'b0);

    $display("[TB] zero");
    apply_stimulus("zero", 25'h0000000, 8'h42, lat);
    check_output("zero", lat, 1, 23'h000000, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("[TB] inf/nan passthrough");
    apply_stimulus("infnan", 25'h0123456, 8'hFF, lat);
    check_output("infnan", lat, 1, 23'h123456, 8'hFF, 1'b0, 1'b0, 1'b0);

    $display("[TB] already normalised");
    apply_stimulus("norm", 25'h0ABCDEF, 8'h10, lat);
    check_output("norm", lat, 1, 23'h2BCDEF, 8'h10, 1'b0, 1'b0, 1'b0);

    $display("[TB] denormal input exponent 1 and 0");
    apply_stimulus("denorm1", 25'h0000100, 8'h01, lat);
    check_output("denorm1", lat, 1, 23'h000100, 8'h00, 1'b0, 1'b1, 1'b0);
    apply_stimulus("denorm0", 25'h0000003, 8'h00, lat);
    check_output("denorm0", lat, 1, 23'h000003, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("[TB] worst case lz=23");
    apply_stimulus("lz23", 25'h0000001, 8'h80, lat);
    check_output("lz23", lat, 7, 23'h000000, 8'h69, 1'b0, 1'b0, 1'b0);

    $display("[TB] underflow after several shifts");
    apply_stimulus("unf_multi", 25'h0000001, 8'h0A, lat);
    check_output("unf_multi", lat, 4, 23'h000200, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("[TB] exponent reaches 1 with hidden bit set");
    apply_stimulus("exp2", 25'h0400000, 8'h02, lat);
    check_output("exp2", lat, 2, 23'h000000, 8'h01, 1'b0, 1'b0, 1'b0);

    $display("[TB] backpressure");
    apply_stimulus("bp", 25'h0040000, 8'h80, lat);
    bus.in_valid    = 1'b1;
    bus.in_mantissa = 25'h1800000;
    bus.in_exponent = 8'hFE;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.hold_valid",    32'(bus.out_valid),    32'd1);
      check("bp.hold_ready",    32'(bus.in_ready),     32'd0);
      check("bp.hold_mantissa", 32'(bus.out_mantissa), 32'h000000);
      check("bp.hold_exponent", 32'(bus.out_exponent), 32'h7B);
    end
    bus.in_valid = 1'b0;
    check_output("bp", lat, 3, 23'h000000, 8'h7B, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset in second SHIFT cycle");
    bus.in_valid    = 1'b1;
    bus.in_mantissa = 25'h0000001;
    bus.in_exponent = 8'h80;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_shift.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_shift.in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_shift.flags",     32'({bus.overflow, bus.underflow, bus.zero}), 32'd0);
    apply_stimulus("after_rst", 25'h1000000, 8'h80, lat);
    check_output("after_rst", lat, 1, 23'h000000, 8'h81, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset wins over output handshake");
    apply_stimulus("rst_hs", 25'h0000000, 8'h42, lat);
    check("rst_hs.zero", 32'(bus.zero), 32'd1);
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    check("rst_hs.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_hs.in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_hs.flags",     32'({bus.overflow, bus.underflow, bus.zero}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
